// File: rtl/valid_array_ctrl.sv
// Request-side controller for a registered-input valid/metadata array.
// Serialises read, set-bits, clear-bits and invalidate-all requests into array-port cycles.
module valid_array_ctrl #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [S_INDEX-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_mask,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_data,
  output logic               csb0,
  output logic               web0,
  output logic [S_INDEX-1:0] addr0,
  output logic [WIDTH-1:0]   din0,
  input  logic [WIDTH-1:0]   dout0
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;
  localparam logic [S_INDEX-1:0] LAST_SET = {S_INDEX{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD    = 2'b01,
    EVAL  = 2'b10,
    SWEEP = 2'b11
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         op_r;
  logic [S_INDEX-1:0] addr_r;
  logic [WIDTH-1:0]   mask_r;
  logic [S_INDEX-1:0] cnt_r;
  logic               accept_s;
  logic [WIDTH-1:0]   new_s;

  function automatic logic [WIDTH-1:0] f_set_bits(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] mask_v);
    return old_v | mask_v;
  endfunction

  function automatic logic [WIDTH-1:0] f_clr_bits(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] mask_v);
    return old_v & ~mask_v;
  endfunction

  // Ready is suppressed during reset so nothing can be accepted while rst0 is high.
  assign req_ready = (state_r == IDLE) && !rst0;
  assign accept_s  = req_valid && req_ready;

  // State, captured request fields and sweep counter.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_r <= IDLE;
      op_r    <= OP_READ;
      addr_r  <= {S_INDEX{1'b0}};
      mask_r  <= {WIDTH{1'b0}};
      cnt_r   <= {S_INDEX{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r   <= req_op;
        addr_r <= req_addr;
        mask_r <= req_mask;
      end
      if (state_r == SWEEP) begin
        cnt_r <= cnt_r + {{(S_INDEX-1){1'b0}}, 1'b1};
      end else if (accept_s) begin
        cnt_r <= {S_INDEX{1'b0}};
      end
    end
  end

  // Modified entry value; read data arrives the cycle after RD, so it feeds EVAL directly.
  always_comb begin
    new_s = dout0;
    case (op_r)
      OP_SET:  new_s = f_set_bits(dout0, mask_r);
      OP_CLR:  new_s = f_clr_bits(dout0, mask_r);
      default: new_s = dout0;
    endcase
  end

  // Next state and array/response decode from registered state and fields.
  always_comb begin
    state_s    = state_r;
    csb0       = 1'b1;
    web0       = 1'b1;
    addr0      = {S_INDEX{1'b0}};
    din0       = {WIDTH{1'b0}};
    resp_valid = 1'b0;
    resp_data  = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_op == OP_INVAL) begin
            state_s = SWEEP;
          end else begin
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        csb0    = 1'b0;
        addr0   = addr_r;
        state_s = EVAL;
      end
      EVAL: begin
        resp_valid = 1'b1;
        resp_data  = dout0;
        if ((op_r != OP_READ) && (new_s != dout0)) begin
          csb0  = 1'b0;
          web0  = 1'b0;
          addr0 = addr_r;
          din0  = new_s;
        end else begin
          csb0 = 1'b1;
        end
        state_s = IDLE;
      end
      SWEEP: begin
        csb0  = 1'b0;
        web0  = 1'b0;
        addr0 = cnt_r;
        if (cnt_r == LAST_SET) begin
          resp_valid = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = SWEEP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

endmodule

// File: doc/valid_array_ctrl.md
Name: valid_array_ctrl

Overview:
Request-side controller for the registered-input valid/metadata arrays (S_INDEX-addressed, WIDTH bits per set, active-low chip select and write enable). It accepts read, set-bits, clear-bits and invalidate-all requests over a valid/ready handshake. It drives the array port and performs read-modify-write with the array's one-cycle read timing. It sits between the cache controller FSM and one valid array instance.

Parameters:
S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX
WIDTH, 1, bits per array entry (e.g. one valid bit per way)

Ports:
clk0  in  1  clock
rst0  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 READ, 01 SET, 10 CLR, 11 INVAL_ALL
req_addr  in  S_INDEX  set index (ignored for INVAL_ALL)
req_mask  in  WIDTH  bits to set or clear (ignored for READ and INVAL_ALL)
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_data  out  WIDTH  entry value before the operation; 0 for INVAL_ALL
csb0  out  1  array chip select, active low
web0  out  1  array write enable, active low
addr0  out  S_INDEX  array address
din0  out  WIDTH  array write data
dout0  in  WIDTH  array read data, valid the cycle after a read is presented

Behaviour:
- Clock and reset: one clock, clk0. Reset rst0 is asynchronous and active-high.
- Reset values: state IDLE, sweep counter 0, csb0=1, web0=1, addr0=0, din0=0, resp_valid=0, resp_data=0. req_ready is forced to 0 while rst0 is high.
- Output registration: all array-side outputs and resp_* are decoded from registered state and registered request fields only. There is no combinational path from req_* to array ports or to resp_*.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. On acceptance, op/addr/mask are captured into registers.
- IDLE: csb0=1, web0=1. On accept:
  - READ, SET or CLR -> RD.
  - INVAL_ALL -> SWEEP with counter=0.
- RD (1 cycle): csb0=0, web0=1, addr0=addr_q -> EVAL.
- EVAL (1 cycle): old = dout0.
  - READ: resp_valid=1, resp_data=old, no array access.
  - SET: new = old | mask_q.
  - CLR: new = old & ~mask_q.
  - If new != old: csb0=0, web0=0, addr0=addr_q, din0=new.
  - If new == old: no array access (csb0=1).
  - In all cases resp_valid=1, resp_data=old, then -> IDLE.
- Latency: accept in cycle 0, RD in cycle 1, response in cycle 2. The next accept can occur in cycle 3.
- Back-to-back hazard: none. The array commits a write one edge after capture, and the next RD is issued no earlier than that commit.
- SWEEP: each cycle csb0=0, web0=0, addr0=counter, din0=0, counter++.
  - In the cycle with counter==NUM_SETS-1: resp_valid=1, resp_data=0, -> IDLE.
  - Occupancy is NUM_SETS cycles; the counter wraps to 0 on exit.
- Width rules: counter is S_INDEX bits plus a terminal compare. The mask operations are bitwise over WIDTH.
- resp_valid is never high in IDLE or RD. Exactly one pulse per accepted request.
- Reset mid-operation: immediate return to IDLE, array outputs deassert asynchronously, no response for the abandoned request.
  - A write captured by the array before reset may still commit.
  - A partially completed sweep leaves the unvisited sets unchanged.
- Illegal or unknown req_op values do not occur (2-bit encoding is fully defined).

Test Plan:
1. Reset with S_INDEX=4, WIDTH=4 -> csb0=1, web0=1, resp_valid=0, req_ready=0 during rst0; req_ready=1 the first cycle after release.
2. Entry 3 preloaded to 4'b1010, READ addr 3 -> cycle 1: csb0=0, web0=1, addr0=3; cycle 2: resp_valid=1, resp_data=4'b1010; no web0=0 at any point.
3. Entry 5=4'b0001, SET addr 5 mask 4'b0100 -> cycle 2: web0=0, addr0=5, din0=4'b0101, resp_data=4'b0001. A following READ of addr 5 returns 4'b0101.
4. Entry 5=4'b0001, CLR mask 4'b0100 -> cycle 2: csb0 stays 1 (no write), resp_valid=1, resp_data=4'b0001.
5. INVAL_ALL -> cycles 1..16: web0=0, din0=0, addr0=0..15 in order; resp_valid=1 only in cycle 16; req_ready=0 throughout. Subsequent READs of sets 0, 7 and 15 all return 0.
6. rst0 asserted mid-sweep at addr0=7 -> csb0=1 and web0=1 immediately without waiting for an edge; no resp_valid. Sets 8..15 retain their prior values. After release req_ready=1 and a READ completes normally.
